// File: rtl/pattern_serializer_if.sv
// ----------------------------------------------------------------------------
// pattern_serializer_if
//   Request and serial-output bundle of the pattern serializer.
//
//   start      request; taken only while busy==0
//   pattern    PAT_W-bit pattern, captured when start is taken
//   reps       CNT_W-bit repetition count, captured when start is taken
//   busy       burst in progress
//   bit_out    serial data bit, 0 whenever bit_valid==0
//   bit_valid  bit_out carries a pattern bit this cycle
//   done       one-cycle pulse in the cycle after the final bit
//
// Handshake: start is a level request. It is taken at any rising clk edge
// where busy==0 (this includes the done cycle) and ignored otherwise.
// Nothing is queued. pattern and reps only matter at that edge.
// The slave modport belongs to the serializer. The master modport belongs
// to whatever drives it.
// ----------------------------------------------------------------------------
interface pattern_serializer_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             busy;
    logic             bit_out;
    logic             bit_valid;
    logic             done;

    modport master (
        output start, pattern, reps,
        input  busy, bit_out, bit_valid, done
    );

    modport slave (
        input  start, pattern, reps,
        output busy, bit_out, bit_valid, done
    );
endinterface

// File: rtl/pattern_serializer.sv
// ----------------------------------------------------------------------------
// pattern_serializer
//   Sends a latched PAT_W-bit pattern MSB-first, one bit per clock.
//   The pattern is repeated max(reps,1) times. GAP idle cycles are inserted
//   between consecutive repetitions.
//
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   bus        pattern_serializer_if.slave (start/pattern/reps in,
//              busy/bit_out/bit_valid/done out, all outputs registered)
//   state_dbg  current FSM state (0 idle, 1 shift, 2 gap)
// ----------------------------------------------------------------------------
module pattern_serializer #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_serializer_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;      // pattern kept for reloads
    logic [PAT_W-1:0] shreg, shreg_n;    // bits still to send, next one at MSB
    logic [BW-1:0]    bit_cnt, bit_cnt_n; // bits left after the current one
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n; // repetitions left, current one included
    logic [GW-1:0]    gap_cnt, gap_cnt_n; // gap cycles left after the current one
    logic             busy_q, busy_n;
    logic             bit_q, bit_n;
    logic             valid_q, valid_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pat_q   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pat_q   <= pat_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            rep_cnt <= rep_cnt_n;
            gap_cnt <= gap_cnt_n;
            busy_q  <= busy_n;
            bit_q   <= bit_n;
            valid_q <= valid_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        rep_cnt_n = rep_cnt;
        gap_cnt_n = gap_cnt;
        busy_n    = busy_q;
        bit_n     = bit_q;
        valid_n   = valid_q;
        done_n    = 1'b0;

        case (state)
            S_IDLE: begin
                busy_n  = 1'b0;
                bit_n   = 1'b0;
                valid_n = 1'b0;
                if (bus.start) begin
                    // The MSB goes straight into the output register, so
                    // the first bit appears one cycle after acceptance.
                    pat_n     = bus.pattern;
                    shreg_n   = bus.pattern << 1;
                    bit_n     = bus.pattern[PAT_W-1];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                    bit_cnt_n = BW'(PAT_W - 1);
                    rep_cnt_n = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
                    state_n   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_cnt != '0) begin
                    bit_n     = shreg[PAT_W-1];
                    shreg_n   = shreg << 1;
                    bit_cnt_n = bit_cnt - 1'b1;
                end else if (rep_cnt != CNT_W'(1)) begin
                    rep_cnt_n = rep_cnt - 1'b1;
                    if (GAP > 0) begin
                        state_n   = S_GAP;
                        gap_cnt_n = GW'((GAP > 0) ? GAP - 1 : 0);
                        bit_n     = 1'b0;
                        valid_n   = 1'b0;
                    end else begin
                        // No gap: the MSB follows bit 0 with no bubble.
                        bit_n     = pat_q[PAT_W-1];
                        shreg_n   = pat_q << 1;
                        bit_cnt_n = BW'(PAT_W - 1);
                    end
                end else begin
                    rep_cnt_n = '0;
                    state_n   = S_IDLE;
                    busy_n    = 1'b0;
                    bit_n     = 1'b0;
                    valid_n   = 1'b0;
                    done_n    = 1'b1;
                end
            end

            S_GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end else begin
                    bit_n     = pat_q[PAT_W-1];
                    shreg_n   = pat_q << 1;
                    bit_cnt_n = BW'(PAT_W - 1);
                    valid_n   = 1'b1;
                    state_n   = S_SHIFT;
                end
            end

            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                bit_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = valid_q;
    assign bus.done      = done_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_pattern_serializer.sv
// ----------------------------------------------------------------------------
// tb_pattern_serializer
//   Drives two serializers (GAP=0 and GAP=2) with identical requests.
//   Each output is compared every cycle against the expected burst. The
//   expected burst is built from the stated rules: max(reps,1) copies of the
//   pattern MSB-first, GAP idle words between copies, then one done word.
// ----------------------------------------------------------------------------
module tb_pattern_serializer;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [1:0]       state0, state2;

    pattern_serializer_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus0 ();
    pattern_serializer_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus2 ();

    assign bus0.start = start;  assign bus0.pattern = pattern;  assign bus0.reps = reps;
    assign bus2.start = start;  assign bus2.pattern = pattern;  assign bus2.reps = reps;

    pattern_serializer #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(state0));
    pattern_serializer #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .state_dbg(state2));

    // scoreboard: words are {busy, bit_valid, bit_out, done}
    typedef logic [3:0] word_q_t[$];
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q2[$];
    logic [3:0] cur0, cur2;
    int checks = 0;
    int errors = 0;

    // 1001 detector on the GAP=0 serial stream (valid bits only)
    logic [3:0] hist0;
    int         nvalid0;
    int         det0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic word_q_t build(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                                      input int gap);
        word_q_t q;
        int n;
        n = (r == 0) ? 1 : int'(r);
        for (int k = 0; k < n; k++) begin
            for (int i = PAT_W - 1; i >= 0; i--) q.push_back({2'b11, p[i], 1'b0});
            if (k < n - 1)
                for (int g = 0; g < gap; g++) q.push_back(4'b1000);
        end
        q.push_back(4'b0001);
        return q;
    endfunction

    // One clock: advance the model at the edge, check 1 ns later, return at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            exp_q0.delete();
            exp_q2.delete();
            cur0 = 4'b0;
            cur2 = 4'b0;
        end else begin
            if (start && !cur0[3]) exp_q0 = build(pattern, reps, 0);
            if (start && !cur2[3]) exp_q2 = build(pattern, reps, 2);
            cur0 = 4'b0;
            cur2 = 4'b0;
            if (exp_q0.size() > 0) cur0 = exp_q0.pop_front();
            if (exp_q2.size() > 0) cur2 = exp_q2.pop_front();
        end
        #1;
        check("gap0_out", {28'd0, bus0.busy, bus0.bit_valid, bus0.bit_out, bus0.done}, {28'd0, cur0});
        check("gap2_out", {28'd0, bus2.busy, bus2.bit_valid, bus2.bit_out, bus2.done}, {28'd0, cur2});
        if (bus0.bit_valid) begin
            hist0 = {hist0[2:0], bus0.bit_out};
            nvalid0++;
            if (nvalid0 >= 4 && hist0 == 4'b1001) det0++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r);
        pattern = p;
        reps    = r;
        start   = 1'b1;
        cycle();
        start   = 1'b0;
    endtask

    task automatic clear_det();
        hist0   = 4'b0;
        nvalid0 = 0;
        det0    = 0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = '0;
        reps    = '0;
        cur0    = 4'b0;
        cur2    = 4'b0;
        clear_det();
        run(3);
        #1;
        check("reset_outs0", {28'd0, bus0.busy, bus0.bit_valid, bus0.bit_out, bus0.done}, 32'd0);
        rst = 1'b0;
        run(2);

        // single 1001
        clear_det();
        send(4'b1001, 8'd1);
        run(6);
        check("det_1001_once", det0, 1);

        // three back-to-back reps of 1001
        clear_det();
        send(4'b1001, 8'd3);
        run(16);
        check("det_1001_x3", det0, 3);

        // 1011 twice: gap visible on the GAP=2 unit
        send(4'b1011, 8'd2);
        run(14);

        // reps=0 sends once; a mid-burst start pulse is ignored
        send(4'b0110, 8'd0);
        run(1);
        send(4'b1111, 8'd3);
        run(6);

        // start held through done: second burst follows immediately
        pattern = 4'b0110;
        reps    = 8'd0;
        start   = 1'b1;
        run(2);
        pattern = 4'b1010;
        run(4);
        start   = 1'b0;
        run(12);

        // asynchronous reset in mid-shift, then a normal restart
        send(4'b1001, 8'd5);
        run(2);
        rst = 1'b1;
        #1;
        check("async_rst0", {29'd0, bus0.busy, bus0.bit_valid, bus0.bit_out}, 32'd0);
        check("async_rst2", {29'd0, bus2.busy, bus2.bit_valid, bus2.bit_out}, 32'd0);
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(2);
        send(4'b1100, 8'd2);
        run(14);

        // largest rep count, no wrap
        send(4'b1000, 8'hFF);
        run(1535);

        // random requests
        for (int it = 0; it < 600; it++) begin
            start   = ($urandom_range(0, 3) == 0);
            pattern = PAT_W'($urandom);
            reps    = CNT_W'($urandom_range(0, 5));
            cycle();
        end
        start = 1'b0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
